multicast_sender: RTL and testbench
===================================

// Module: multicast_sender
// PURPOSE
//  Transmit side of the PE multicast bus. Queues {tag, value} pairs from the global buffer
//  and drives enable/tag/value onto the bus shared by all multicast_controller instances.
//  Holds each beat until the aggregated PE ready (bus_ready) accepts it.
//  Sits between the global-buffer scatter logic and the PE array.
// PARAMETERS
//  ADDRESS_WIDTH  4   tag width; must match the receiving controllers.
//  BITWIDTH       16  data value width.
//  FIFO_DEPTH     4   input queue entries; power of 2, >= 2.
//  COUNT_WIDTH    8   width of the sent-beat counter.
// PORTS
//  clk           in   1              clock, rising edge.
//  rstb          in   1              asynchronous active-low reset.
//  in_valid      in   1              upstream offers in_tag/in_value.
//  in_ready      out  1              queue can accept; write = in_valid & in_ready at posedge.
//  in_tag        in   ADDRESS_WIDTH  destination tag of the offered beat.
//  in_value      in   BITWIDTH       data of the offered beat.
//  flush         in   1              synchronous discard of all queued/pending beats.
//  bus_ready     in   1              OR/AND-reduced PE ready from the array.
//  enable        out  1              bus beat valid.
//  tag           out  ADDRESS_WIDTH  bus destination tag.
//  value         out  BITWIDTH       bus data.
//  busy          out  1              high while the FIFO or output register holds a beat.
//  sent_count    out  COUNT_WIDTH    beats accepted since reset.
// BEHAVIOUR
//  - Reset (rstb low, async): FIFO empty, ptrs 0, state IDLE; enable=0, tag=0, value=0,
//    busy=0, sent_count=0. in_ready=1 immediately after reset is released.
//  - Structure: FIFO_DEPTH-entry FIFO -> one output register (enable/tag/value).
//    Total buffering = FIFO_DEPTH+1 beats.
//  - in_ready = !fifo_full & !flush (combinational). No write-through when full.
//  - Transfer: occurs at posedge where enable & bus_ready.
//  - While enable=1 & bus_ready=0, tag/value/enable hold stable (no change, no loss).
//  - Output register loads FIFO head at posedge when empty or transferring.
//    Gives back-to-back beats, one per cycle, in write order.
//  - Latency: beat written at edge N into an empty block -> enable=1 with that tag/value
//    after edge N+1.
//  - When a beat leaves and none replaces it: enable=0, tag=0, value=0.
//  - FSM:
//      IDLE  : enable=0. -> SEND when FIFO non-empty.
//      SEND  : enable=1. -> IDLE on transfer with FIFO empty; else stays in SEND.
//      FLUSH : one cycle; entered from any state when flush=1. Clears FIFO and output
//              register; enable=0 after that edge; -> IDLE.
//  - flush priority: flush overrides a same-cycle write (in_ready=0) and a same-cycle
//    transfer. A same-cycle transfer is not counted.
//  - Simultaneous FIFO read and write in one edge: allowed. Occupancy unchanged.
//  - sent_count: +1 per transfer, wraps modulo 2^COUNT_WIDTH (255 -> 0). Unaffected by flush.
//  - busy = fifo_non_empty | enable.
//  - bus_ready while enable=0: ignored.
//  - Reset mid-transfer: all state cleared asynchronously; the pending beat is lost.
// TESTING
//  1 Reset: hold rstb=0 -> enable/tag/value/busy/sent_count all 0; after release in_ready=1.
//  2 Single beat: write tag=3, value=257 at edge N, bus_ready=1 -> enable=1, tag=3, value=257
//    after N+1; enable=0, sent_count=1 after N+2.
//  3 Stall: tag=2, value=512 pending, bus_ready=0 for 5 cycles -> outputs stable every cycle.
//    Then bus_ready=1 -> one transfer, sent_count increments once.
//  4 Fill/drain (DEPTH=4): bus_ready=0, offer 6 beats (tags 0..5) -> 5 accepted,
//    in_ready=0 on the 6th. Then bus_ready=1 -> tags 0..4 on 5 consecutive cycles, in order.
//  5 Flush: 3 beats queued, flush=1 together with in_valid=1 -> nothing written; enable=0
//    next cycle; busy=0; sent_count unchanged.
//  6 Wrap/reset: 256 transfers -> sent_count returns to 0. rstb low while enable=1 ->
//    outputs 0 asynchronously.

Source files
------------

// File: rtl/multicast_sender.sv
// multicast_sender
//    Transmit side of the PE multicast bus. {tag, value} beats from the global
//    buffer are queued in a small FIFO, then presented one at a time on the bus
//    (enable/tag/value) until the aggregated PE ready (bus_ready) accepts them.
//
//    Ports
//       clk          rising-edge clock
//       rstb         asynchronous active-low reset
//       in_valid     upstream offers in_tag/in_value
//       in_ready     queue can accept (write = in_valid & in_ready)
//       in_tag       destination tag of the offered beat
//       in_value     data of the offered beat
//       flush        synchronous discard of all queued/pending beats
//       bus_ready    aggregated PE ready
//       enable       bus beat valid
//       tag          bus destination tag
//       value        bus data
//       busy         FIFO or output register holds a beat
//       sent_count   beats accepted by the bus since reset (wraps)
//
//    state    | meaning
//    ---------+-------------------------------------------------------------
//    ST_IDLE  | output register empty, enable=0; loads when FIFO non-empty
//    ST_SEND  | output register holds a beat, enable=1, waiting for bus_ready
//    ST_FLUSH | one cycle after a flush edge; FIFO and output already cleared
module multicast_sender #(
   parameter int ADDRESS_WIDTH = 4,
   parameter int BITWIDTH      = 16,
   parameter int FIFO_DEPTH    = 4,
   parameter int COUNT_WIDTH   = 8
) (
   input  logic                     clk,
   input  logic                     rstb,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDRESS_WIDTH-1:0] in_tag,
   input  logic [BITWIDTH-1:0]      in_value,
   input  logic                     flush,
   input  logic                     bus_ready,
   output logic                     enable,
   output logic [ADDRESS_WIDTH-1:0] tag,
   output logic [BITWIDTH-1:0]      value,
   output logic                     busy,
   output logic [COUNT_WIDTH-1:0]   sent_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = ADDRESS_WIDTH + BITWIDTH;
   localparam logic [AW:0]          PTR_ONE = 1;
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t        state;
   logic [EW-1:0] mem [FIFO_DEPTH];
   // One extra pointer bit distinguishes full from empty.
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          fifo_empty;
   logic          fifo_full;
   logic          fifo_wr;
   logic          fifo_rd;
   logic          transfer;
   logic          load_out;
   logic [EW-1:0] head;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready   = !fifo_full && !flush;
   assign fifo_wr    = in_valid && in_ready;
   // flush wins over a same-cycle bus acceptance; that beat is dropped, not counted.
   assign transfer   = enable && bus_ready && !flush;
   // Output register is free to take a new beat when empty or being drained this edge.
   assign load_out   = (state != ST_FLUSH) && !flush && (!enable || transfer);
   assign fifo_rd    = load_out && !fifo_empty;
   assign head       = mem[rd_ptr[AW-1:0]];
   assign busy       = !fifo_empty || enable;

   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         mem[wr_ptr[AW-1:0]] <= {in_tag, in_value};
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (fifo_rd) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state      <= ST_IDLE;
         enable     <= 1'b0;
         tag        <= '0;
         value      <= '0;
         sent_count <= '0;
      end else begin
         if (transfer) sent_count <= sent_count + CNT_ONE;

         if (flush) begin
            state  <= ST_FLUSH;
            enable <= 1'b0;
            tag    <= '0;
            value  <= '0;
         end else begin
            case (state)
               ST_IDLE, ST_SEND: begin
                  if (load_out) begin
                     if (!fifo_empty) begin
                        state  <= ST_SEND;
                        enable <= 1'b1;
                        tag    <= head[EW-1:BITWIDTH];
                        value  <= head[BITWIDTH-1:0];
                     end else begin
                        state  <= ST_IDLE;
                        enable <= 1'b0;
                        tag    <= '0;
                        value  <= '0;
                     end
                  end
               end
               ST_FLUSH: begin
                  state <= ST_IDLE;
               end
               default: begin
                  state  <= ST_IDLE;
                  enable <= 1'b0;
                  tag    <= '0;
                  value  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_multicast_sender.sv
module tb_multicast_sender;

   localparam int AW    = 4;
   localparam int BW    = 16;
   localparam int DEPTH = 4;
   localparam int CW    = 8;

   logic          clk = 1'b0;
   logic          rstb = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_tag = '0;
   logic [BW-1:0] in_value = '0;
   logic          flush = 1'b0;
   logic          bus_ready = 1'b0;
   logic          enable;
   logic [AW-1:0] tag;
   logic [BW-1:0] value;
   logic          busy;
   logic [CW-1:0] sent_count;

   int total = 0;
   int bad   = 0;
   bit mon_on = 1'b0;

   typedef struct packed {
      logic [AW-1:0] t;
      logic [BW-1:0] v;
   } beat_t;

   // Reference model: every accepted beat in write order, plus the expected count.
   beat_t         exp_q[$];
   logic [CW-1:0] exp_count = '0;
   beat_t         prev_beat;
   beat_t         mon_exp;
   bit            prev_stall = 1'b0;

   multicast_sender #(
      .ADDRESS_WIDTH(AW),
      .BITWIDTH(BW),
      .FIFO_DEPTH(DEPTH),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rstb(rstb),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_tag(in_tag),
      .in_value(in_value),
      .flush(flush),
      .bus_ready(bus_ready),
      .enable(enable),
      .tag(tag),
      .value(value),
      .busy(busy),
      .sent_count(sent_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change just after posedge; acceptance is sampled mid-cycle.
   task automatic drive(input logic v, input logic [AW-1:0] t, input logic [BW-1:0] d,
                        input logic f, input logic br, output bit acc);
      in_valid  = v;
      in_tag    = t;
      in_value  = d;
      flush     = f;
      bus_ready = br;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back({t, d});
      @(posedge clk);
      #1;
   endtask

   // Monitor: checks the bus against the model and predicts the coming edge.
   always @(negedge clk) begin
      if (mon_on) begin
         chk("sent_count", sent_count, exp_count);
         if (!enable) begin
            chk("idle_tag", tag, 0);
            chk("idle_value", value, 0);
         end
         if (prev_stall) begin
            chk("stall_enable", enable, 1);
            chk("stall_beat", {tag, value}, prev_beat);
         end
         if (flush) begin
            exp_q.delete();
            prev_stall = 1'b0;
         end else begin
            if (enable && bus_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_beat: got tag=%0h value=%0h expected none", tag, value);
               end else begin
                  mon_exp = exp_q.pop_front();
                  chk("beat", {tag, value}, mon_exp);
                  exp_count = exp_count + 1'b1;
               end
            end
            prev_stall = enable && !bus_ready;
            prev_beat  = {tag, value};
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      bit            acc;
      int            n_acc;
      logic [CW-1:0] snap;

      // 1 reset
      #12;
      chk("rst_enable", enable, 0);
      chk("rst_tag", tag, 0);
      chk("rst_value", value, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", sent_count, 0);
      @(posedge clk);
      #1;
      rstb = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      exp_count = '0;
      mon_on = 1'b1;

      // 2 single beat
      drive(1'b1, 4'd3, 16'd257, 1'b0, 1'b1, acc);
      chk("t2_accept", acc, 1);
      chk("t2_latency", enable, 0);
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk("t2_enable", enable, 1);
      chk("t2_tag", tag, 3);
      chk("t2_value", value, 257);
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk("t2_done_enable", enable, 0);
      chk("t2_count", sent_count, 1);

      // 3 stall
      drive(1'b1, 4'd2, 16'd512, 1'b0, 1'b0, acc);
      drive(1'b0, '0, '0, 1'b0, 1'b0, acc);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, '0, '0, 1'b0, 1'b0, acc);
         chk("t3_hold_enable", enable, 1);
         chk("t3_hold_tag", tag, 2);
         chk("t3_hold_value", value, 512);
      end
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk("t3_count", sent_count, 2);
      chk("t3_enable", enable, 0);
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk("t3_count_once", sent_count, 2);

      // 4 fill / drain
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, AW'(i), BW'(16'h100 + i), 1'b0, 1'b0, acc);
         n_acc += int'(acc);
         if (i == 5) chk("t4_sixth_rejected", acc, 0);
      end
      chk("t4_accepted", n_acc, DEPTH + 1);
      for (int i = 0; i < 5; i++) begin
         chk("t4_order_enable", enable, 1);
         chk("t4_order_tag", tag, i);
         drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
      end
      chk("t4_drained_enable", enable, 0);
      chk("t4_drained_busy", busy, 0);

      // 5 flush
      for (int i = 0; i < 3; i++) drive(1'b1, AW'(7 + i), BW'(700 + i), 1'b0, 1'b0, acc);
      snap = exp_count;
      drive(1'b1, 4'd9, 16'd99, 1'b1, 1'b0, acc);
      chk("t5_flush_blocks_write", acc, 0);
      chk("t5_enable", enable, 0);
      chk("t5_busy", busy, 0);
      chk("t5_count", sent_count, snap);
      drive(1'b1, 4'd5, 16'd55, 1'b0, 1'b0, acc);
      drive(1'b0, '0, '0, 1'b0, 1'b0, acc);
      drive(1'b0, '0, '0, 1'b0, 1'b0, acc);
      chk("t5_pending_enable", enable, 1);
      snap = exp_count;
      drive(1'b0, '0, '0, 1'b1, 1'b1, acc);
      chk("t5_flush_xfer_count", sent_count, snap);
      chk("t5_flush_xfer_enable", enable, 0);
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk("t5_after_busy", busy, 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), AW'($urandom), BW'($urandom),
               1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0), acc);
      end
      for (int i = 0; i < 12; i++) drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk("rand_drain_empty", exp_q.size(), 0);
      chk("rand_enable", enable, 0);
      chk("rand_busy", busy, 0);

      // 6 wrap
      mon_on = 1'b0;
      @(negedge clk);
      #1;
      rstb = 1'b0;
      #1;
      rstb = 1'b1;
      exp_q.delete();
      exp_count = '0;
      @(posedge clk);
      #1;
      mon_on = 1'b1;
      for (int i = 0; i < 256; i++) drive(1'b1, AW'(i), BW'(i * 3), 1'b0, 1'b1, acc);
      for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk("t6_wrap_count", sent_count, 0);
      chk("t6_all_sent", exp_q.size(), 0);

      // 6 async reset while a beat is pending
      drive(1'b1, 4'hA, 16'h1234, 1'b0, 1'b1, acc);
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
      drive(1'b1, 4'hB, 16'hBEEF, 1'b0, 1'b0, acc);
      drive(1'b0, '0, '0, 1'b0, 1'b0, acc);
      chk("t6_pending_enable", enable, 1);
      chk("t6_pending_count", sent_count, 1);
      mon_on = 1'b0;
      #2;
      rstb = 1'b0;
      #1;
      chk("t6_arst_enable", enable, 0);
      chk("t6_arst_tag", tag, 0);
      chk("t6_arst_value", value, 0);
      chk("t6_arst_busy", busy, 0);
      chk("t6_arst_count", sent_count, 0);
      @(negedge clk);
      rstb = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
